full_adder_multibit_sync: RTL and testbench



---
 rtl/full_adder_pkg.sv | 20 ++
 rtl/full_adder_bit.sv | 23 ++
 rtl/full_adder_multibit_sync.sv | 60 ++++++
 tb/tb_full_adder_multibit_sync.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared definitions for the multi-bit registered full adder.
//   DEFAULT_WIDTH : default operand width of full_adder_multibit_sync.
//   ref_add       : behavioural reference sum {carry_out, sum} of two unsigned
//                   operands plus a carry-in. Operands are carried at the
//                   maximum supported width (64). Callers mask the operands to
//                   their own width, and the result then fits in width+1 bits.
package full_adder_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int MAX_WIDTH     = 64;

  function automatic logic [MAX_WIDTH:0] ref_add(input logic [MAX_WIDTH-1:0] a,
                                                 input logic [MAX_WIDTH-1:0] b,
                                                 input logic                 cin);
    logic [MAX_WIDTH:0] res;
    res = {1'b0, a} + {1'b0, b} + {{MAX_WIDTH{1'b0}}, cin};
    return res;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder cell, purely combinational. It is the ripple element of
// full_adder_multibit_sync.
//   a_i, b_i : operand bits
//   c_i      : carry in from the next lower bit
//   s_o      : sum bit
//   co_o     : carry out to the next higher bit
module full_adder_bit
  import full_adder_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  logic prop;

  assign prop = a_i ^ b_i;
  assign s_o  = prop ^ c_i;
  assign co_o = (a_i & b_i) | (c_i & prop);

endmodule

// File: rtl/full_adder_multibit_sync.sv
// Parameterised ripple-carry adder with a registered result (1-cycle latency).
// F_o = zero-extend(A_i) + zero-extend(B_i) + C_i, computed in WIDTH+1 bits.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset. It clears F_o and valid_o.
//   valid_i : qualifies A_i/B_i/C_i for this cycle
//   A_i,B_i : unsigned operands, WIDTH bits
//   C_i     : carry in
//   F_o     : {carry_out, sum}, WIDTH+1 bits. It holds its value while valid_i = 0.
//   valid_o : registered copy of valid_i
module full_adder_multibit_sync
  import full_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             C_i,
  output logic [WIDTH:0]   F_o,
  output logic             valid_o
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   f_p0;
  logic             vld_p0;

  assign carry[0] = C_i;

  for (genvar k = 0; k < WIDTH; k++) begin : g_ripple
    full_adder_bit u_bit (
      .a_i  (A_i[k]),
      .b_i  (B_i[k]),
      .c_i  (carry[k]),
      .s_o  (sum[k]),
      .co_o (carry[k+1])
    );
  end

  // ---- stage p0: output register ----
  // The data register loads only on qualified cycles. Unknown operands on idle
  // cycles therefore never reach F_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      f_p0   <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= valid_i;
      if (valid_i) begin
        f_p0 <= {carry[WIDTH], sum};
      end
    end
  end

  assign F_o     = f_p0;
  assign valid_o = vld_p0;

endmodule

// File: tb/tb_full_adder_multibit_sync.sv
module tb_full_adder_multibit_sync;
  import full_adder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Three instances: WIDTH = 1, 8 and 16.
  logic        v1, v8, v16;
  logic [0:0]  a1, b1;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        c1, c8, c16;
  logic [1:0]  f1;
  logic [8:0]  f8;
  logic [16:0] f16;
  logic        vo1, vo8, vo16;

  full_adder_multibit_sync #(.WIDTH(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(v1), .A_i(a1), .B_i(b1), .C_i(c1),
    .F_o(f1), .valid_o(vo1));
  full_adder_multibit_sync #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .valid_i(v8), .A_i(a8), .B_i(b8), .C_i(c8),
    .F_o(f8), .valid_o(vo8));
  full_adder_multibit_sync #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .valid_i(v16), .A_i(a16), .B_i(b16), .C_i(c16),
    .F_o(f16), .valid_o(vo16));

  typedef struct {
    int          sel;
    logic [64:0] f;
    logic        v;
    string       nm;
  } exp_t;

  typedef struct {
    int          sel;
    logic [63:0] a;
    logic [63:0] b;
    logic        c;
    logic        v;
    logic [64:0] exp_f;
    string       nm;
  } vec_t;

  exp_t        sbq[$];
  logic [64:0] held[3];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int wid(input int sel);
    return (sel == 0) ? 1 : (sel == 1) ? 8 : 16;
  endfunction

  function automatic logic [64:0] actual_f(input int sel);
    case (sel)
      0:       return {63'd0, f1};
      1:       return {56'd0, f8};
      default: return {48'd0, f16};
    endcase
  endfunction

  function automatic logic actual_v(input int sel);
    case (sel)
      0:       return vo1;
      1:       return vo8;
      default: return vo16;
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [64:0] act, input logic [64:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the expected output.
  task automatic drive(input int sel, input logic [63:0] a, input logic [63:0] b,
                       input logic c, input logic v, input logic [64:0] exp_f,
                       input string nm);
    @(negedge clk);
    v1 = 1'b0; v8 = 1'b0; v16 = 1'b0;
    case (sel)
      0: begin a1 = a[0:0];  b1 = b[0:0];  c1 = c;  v1 = v;  end
      1: begin a8 = a[7:0];  b8 = b[7:0];  c8 = c;  v8 = v;  end
      default: begin a16 = a[15:0]; b16 = b[15:0]; c16 = c; v16 = v; end
    endcase
    if (v) held[sel] = exp_f;
    sbq.push_back('{sel, held[sel], v, nm});
  endtask

  // Pop one expectation and compare it 1 time unit after the next rising edge.
  task automatic check_next();
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries required 1");
      return;
    end
    e = sbq.pop_front();
    cmp({e.nm, "_F"}, actual_f(e.sel), e.f);
    cmp({e.nm, "_valid"}, {64'd0, actual_v(e.sel)}, {64'd0, e.v});
  endtask

  task automatic step(input int sel, input logic [63:0] a, input logic [63:0] b,
                      input logic c, input logic v, input logic [64:0] exp_f,
                      input string nm);
    drive(sel, a, b, c, v, exp_f, nm);
    check_next();
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{0, 64'h0,    64'h0,    1'b0, 1'b1, 65'h0,     "w1_000"};
    vecs[1] = '{0, 64'h1,    64'h0,    1'b0, 1'b1, 65'h1,     "w1_100"};
    vecs[2] = '{0, 64'h0,    64'h1,    1'b1, 1'b1, 65'h2,     "w1_011"};
    vecs[3] = '{0, 64'h1,    64'h1,    1'b1, 1'b1, 65'h3,     "w1_111"};
    vecs[4] = '{1, 64'hFF,   64'hFF,   1'b1, 1'b1, 65'h1FF,   "w8_max"};
    vecs[5] = '{1, 64'h80,   64'h80,   1'b0, 1'b1, 65'h100,   "w8_cout_only"};
    vecs[6] = '{2, 64'hFFFF, 64'h0001, 1'b0, 1'b1, 65'h10000, "w16_ripple"};
    vecs[7] = '{1, 64'h12,   64'h34,   1'b0, 1'b1, 65'h046,   "w8_load"};
    vecs[8] = '{1, 64'hAA,   64'hx,    1'bx, 1'b0, 65'h0,     "w8_hold"};

    v1 = 0; v8 = 0; v16 = 0;
    a1 = '0; b1 = '0; c1 = 0; a8 = '0; b8 = '0; c8 = 0; a16 = '0; b16 = '0; c16 = 0;
    for (int i = 0; i < 3; i++) held[i] = '0;

    // Reset state
    #12;
    for (int s = 0; s < 3; s++) begin
      cmp("reset_F", actual_f(s), 65'h0);
      cmp("reset_valid", {64'd0, actual_v(s)}, 65'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Table vectors, back-to-back
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].v,
            vecs[i].exp_f, vecs[i].nm);
      check_next();
    end

    // Pipelined overlap: three W1 ops on consecutive edges, checks interleaved
    fork
      begin
        drive(0, 64'h1, 64'h0, 1'b0, 1'b1, 65'h1, "w1_pipe_a");
        drive(0, 64'h0, 64'h1, 1'b1, 1'b1, 65'h2, "w1_pipe_b");
        drive(0, 64'h1, 64'h1, 1'b1, 1'b1, 65'h3, "w1_pipe_c");
      end
      begin
        check_next(); check_next(); check_next();
      end
    join

    // Reset asserted between edges while W8 holds 9'h046
    @(negedge clk);
    v1 = 0; v8 = 0; v16 = 0;
    cmp("w8_pre_reset_F", actual_f(1), 65'h046);
    #1 rst = 1'b1;
    #1;
    cmp("midreset_F", actual_f(1), 65'h0);
    cmp("midreset_valid", {64'd0, actual_v(1)}, 65'h0);
    for (int i = 0; i < 3; i++) held[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    step(1, 64'h0, 64'h0, 1'b0, 1'b0, 65'h0, "post_reset_idle");
    step(1, 64'h0F, 64'h01, 1'b1, 1'b1, 65'h011, "post_reset_first");

    // Random: W1 and W16, random valid, pipelined
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          int          s;
          logic [63:0] ra, rb;
          logic        rc, rv;
          s  = (i % 2 == 0) ? 0 : 2;
          ra = {$urandom, $urandom} & ((64'd1 << wid(s)) - 1);
          rb = {$urandom, $urandom} & ((64'd1 << wid(s)) - 1);
          rc = 1'($urandom_range(0, 1));
          rv = 1'($urandom_range(0, 1));
          drive(s, ra, rb, rc, rv, ref_add(ra, rb, rc), "rand");
        end
      end
      begin
        for (int i = 0; i < 1000; i++) check_next();
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
